fast9_scan_ctrl: RTL and testbench

//  Raster-scan sequencer for the FAST9 detection/score datapath. Walks every interior reference pixel of a

---
 rtl/fast9_pkg.sv | 24 ++
 rtl/fast9_circle_addr.sv | 25 ++
 rtl/fast9_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fast9_scan_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast9_pkg.sv
// Shared types and constants for the FAST9 raster-scan controller.
// The circle tables list the 16 Bresenham neighbours (radius 3) in FD/FS lane order.
package fast9_pkg;

  localparam int PIX_W    = 8;
  localparam int N_CIRCLE = 16;
  localparam int N_SLOT   = N_CIRCLE + 1;
  localparam int SLOT_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_ISSUE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int CIRCLE_DX [N_CIRCLE] = '{ 0,  1,  2,  3,  3,  3,  2,  1,
                                           0, -1, -2, -3, -3, -3, -2, -1};
  localparam int CIRCLE_DY [N_CIRCLE] = '{-3, -3, -2, -1,  0,  1,  2,  3,
                                           3,  3,  2,  1,  0, -1, -2, -3};

endpackage

// File: rtl/fast9_circle_addr.sv
// Maps a fetch slot to a RAM address: slot 0 is the centre pixel,
// slots 1..16 are circle neighbours k = slot-1 around the centre.
module fast9_circle_addr
  import fast9_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int ADDR_W = 15
) (
  input  logic [ADDR_W-1:0] refAddr_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [3:0]        k;
  logic [ADDR_W-1:0] offset;

  // The offset wraps modulo 2**ADDR_W, which gives the same low bits as a
  // wider signed add; interior-only scanning keeps the true result in range.
  always_comb begin
    k      = 4'(slot_i - SLOT_W'(1));
    offset = ADDR_W'(CIRCLE_DY[k] * IMG_W + CIRCLE_DX[k]);
    addr_o = (slot_i == '0) ? refAddr_i : refAddr_i + offset;
  end

endmodule

// File: rtl/fast9_scan_ctrl.sv
// Raster-scan sequencer feeding centre + 16 circle pixels to the FAST9 FD/FS cores,
// with a saturating corner counter and frame-done pulse.
module fast9_scan_ctrl
  import fast9_pkg::*;
#(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 15,
  parameter int BORDER  = 3,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      nReset,
  input  logic                      start,
  input  logic [7:0]                thresIn,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         memAddr,
  output logic                      memRe,
  input  logic [7:0]                memData,
  output logic [ADDR_W-1:0]         refAddr,
  output logic [PIX_W-1:0]          refPixel,
  output logic [PIX_W*N_CIRCLE-1:0] adjPixel,
  output logic [7:0]                thres,
  output logic                      pixValid,
  input  logic                      pixReady,
  input  logic                      cornerValid,
  input  logic                      isCorner,
  output logic [CNT_W-1:0]          cornerCount
);

  localparam int CRD_W = 16;
  localparam bit DEGEN = (IMG_W <= 2*BORDER) || (IMG_H <= 2*BORDER);

  localparam logic [CRD_W-1:0]  X_FIRST    = CRD_W'(BORDER);
  localparam logic [CRD_W-1:0]  X_LAST     = CRD_W'(IMG_W - 1 - BORDER);
  localparam logic [CRD_W-1:0]  Y_LAST     = CRD_W'(IMG_H - 1 - BORDER);
  localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(BORDER*IMG_W + BORDER);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(2*BORDER + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(N_SLOT - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [2:0]          drain_q, drain_d;
  logic [CRD_W-1:0]    x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]   refAddr_q, refAddr_d;
  logic [7:0]          thres_q, thres_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [MEM_LAT-1:0]  tagValid_q;
  logic [SLOT_W-1:0]   tagSlot_q [MEM_LAT];
  logic [PIX_W-1:0]    refPixel_q;
  logic [PIX_W*N_CIRCLE-1:0] adjPixel_q;
  logic [ADDR_W-1:0]   circAddr;

  fast9_circle_addr #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_circle_addr (
    .refAddr_i (refAddr_q),
    .slot_i    (slot_q),
    .addr_o    (circAddr)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    drain_d   = drain_q;
    x_d       = x_q;
    y_d       = y_q;
    refAddr_d = refAddr_q;
    thres_d   = thres_q;
    count_d   = count_q;
    memRe     = 1'b0;
    pixValid  = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          thres_d   = thresIn;
          x_d       = X_FIRST;
          y_d       = CRD_W'(BORDER);
          refAddr_d = BASE_ADDR;
          slot_d    = '0;
          state_d   = DEGEN ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        memRe = 1'b1;
        if (slot_q == LAST_SLOT) begin
          slot_d  = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = S_ISSUE;
        else                       drain_d = drain_q + 3'd1;
      end
      S_ISSUE: begin
        pixValid = 1'b1;
        if (pixReady) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = S_DONE;
          end else begin
            x_d       = X_FIRST;
            y_d       = y_q + CRD_W'(1);
            refAddr_d = refAddr_q + ROW_STEP;
            state_d   = S_FETCH;
          end
        end else begin
          x_d       = x_q + CRD_W'(1);
          refAddr_d = refAddr_q + ADDR_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // FD results may trail the last handshake, so counting is state-independent.
    if (state_q == S_IDLE && start) begin
      count_d = '0;
    end else if (cornerValid && isCorner && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      drain_q   <= '0;
      x_q       <= CRD_W'(BORDER);
      y_q       <= CRD_W'(BORDER);
      refAddr_q <= '0;
      thres_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      drain_q   <= drain_d;
      x_q       <= x_d;
      y_q       <= y_d;
      refAddr_q <= refAddr_d;
      thres_q   <= thres_d;
      count_q   <= count_d;
    end
  end

  // Slot tags ride alongside the RAM pipeline so returning data lands in the right lane.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      tagValid_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) tagSlot_q[i] <= '0;
    end else begin
      tagValid_q[0] <= memRe;
      tagSlot_q[0]  <= slot_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagSlot_q[i]  <= tagSlot_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      refPixel_q <= '0;
      adjPixel_q <= '0;
    end else if (tagValid_q[MEM_LAT-1]) begin
      if (tagSlot_q[MEM_LAT-1] == '0) refPixel_q <= memData;
      for (int k = 0; k < N_CIRCLE; k++) begin
        if (tagSlot_q[MEM_LAT-1] == SLOT_W'(k + 1)) adjPixel_q[k*PIX_W +: PIX_W] <= memData;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign memAddr     = memRe ? circAddr : '0;
  assign refAddr     = refAddr_q;
  assign refPixel    = refPixel_q;
  assign adjPixel    = adjPixel_q;
  assign thres       = thres_q;
  assign cornerCount = count_q;

endmodule

// File: tb/tb_fast9_scan_ctrl.sv
// Scoreboard bench for fast9_scan_ctrl on a 16x16 ramp image (data = addr[7:0]),
// covering MEM_LAT=1 and MEM_LAT=3/CNT_W=2 builds plus a degenerate frame.
`timescale 1ns/1ps
module tb_fast9_scan_ctrl;

  localparam int W  = 16;
  localparam int AW = 8;

  localparam int DX [16] = '{ 0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3, -3, -3, -2, -1};
  localparam int DY [16] = '{-3, -3, -2, -1,  0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3};

  typedef struct packed {
    logic [7:0]   refAddr;
    logic [7:0]   refPixel;
    logic [127:0] adj;
  } exp_t;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       nReset = 1'b0;
  logic       start = 1'b0, pixReady = 1'b0, cornerValid = 1'b0, isCorner = 1'b0, sel = 1'b0;
  logic       cStart = 1'b0;
  logic [7:0] thresIn = 8'h00;

  logic aStart, aCv, bStart, bCv;
  assign aStart = start & ~sel;
  assign aCv    = cornerValid & ~sel;
  assign bStart = start & sel;
  assign bCv    = cornerValid & sel;

  logic          aBusy, aDone, aMemRe, aPixValid;
  logic [AW-1:0] aMemAddr, aRefAddr;
  logic [7:0]    aMemData, aRefPixel, aThres;
  logic [127:0]  aAdj;
  logic [15:0]   aCount;

  logic          bBusy, bDone, bMemRe, bPixValid;
  logic [AW-1:0] bMemAddr, bRefAddr;
  logic [7:0]    bMemData, bRefPixel, bThres;
  logic [127:0]  bAdj;
  logic [1:0]    bCount;

  logic          cBusy, cDone, cMemRe, cPixValid;
  logic [AW-1:0] cMemAddr, cRefAddr;
  logic [7:0]    cRefPixel, cThres;
  logic [127:0]  cAdj;
  logic [15:0]   cCount;

  fast9_scan_ctrl #(.IMG_W(W), .IMG_H(16), .ADDR_W(AW), .BORDER(3), .MEM_LAT(1), .CNT_W(16)) dutA (
    .clock(clock), .nReset(nReset), .start(aStart), .thresIn(thresIn),
    .busy(aBusy), .done(aDone), .memAddr(aMemAddr), .memRe(aMemRe), .memData(aMemData),
    .refAddr(aRefAddr), .refPixel(aRefPixel), .adjPixel(aAdj), .thres(aThres),
    .pixValid(aPixValid), .pixReady(pixReady), .cornerValid(aCv), .isCorner(isCorner),
    .cornerCount(aCount)
  );

  fast9_scan_ctrl #(.IMG_W(W), .IMG_H(16), .ADDR_W(AW), .BORDER(3), .MEM_LAT(3), .CNT_W(2)) dutB (
    .clock(clock), .nReset(nReset), .start(bStart), .thresIn(thresIn),
    .busy(bBusy), .done(bDone), .memAddr(bMemAddr), .memRe(bMemRe), .memData(bMemData),
    .refAddr(bRefAddr), .refPixel(bRefPixel), .adjPixel(bAdj), .thres(bThres),
    .pixValid(bPixValid), .pixReady(pixReady), .cornerValid(bCv), .isCorner(isCorner),
    .cornerCount(bCount)
  );

  fast9_scan_ctrl #(.IMG_W(6), .IMG_H(16), .ADDR_W(AW), .BORDER(3), .MEM_LAT(1), .CNT_W(16)) dutC (
    .clock(clock), .nReset(nReset), .start(cStart), .thresIn(thresIn),
    .busy(cBusy), .done(cDone), .memAddr(cMemAddr), .memRe(cMemRe), .memData(8'h00),
    .refAddr(cRefAddr), .refPixel(cRefPixel), .adjPixel(cAdj), .thres(cThres),
    .pixValid(cPixValid), .pixReady(1'b1), .cornerValid(1'b0), .isCorner(1'b0),
    .cornerCount(cCount)
  );

  // Ramp RAMs: read data is the low address byte, MEM_LAT cycles after the read.
  logic [7:0] bPipe [3];
  always @(posedge clock) aMemData <= aMemRe ? aMemAddr : 8'hxx;
  always @(posedge clock) begin
    bPipe[0] <= bMemRe ? bMemAddr : 8'hxx;
    bPipe[1] <= bPipe[0];
    bPipe[2] <= bPipe[1];
  end
  assign bMemData = bPipe[2];

  logic          obsBusy, obsDone, obsMemRe, obsPixValid;
  logic [AW-1:0] obsRefAddr;
  logic [7:0]    obsRefPixel, obsThres;
  logic [127:0]  obsAdj;
  logic [15:0]   obsCount;
  assign obsBusy     = sel ? bBusy     : aBusy;
  assign obsDone     = sel ? bDone     : aDone;
  assign obsMemRe    = sel ? bMemRe    : aMemRe;
  assign obsPixValid = sel ? bPixValid : aPixValid;
  assign obsRefAddr  = sel ? bRefAddr  : aRefAddr;
  assign obsRefPixel = sel ? bRefPixel : aRefPixel;
  assign obsThres    = sel ? bThres    : aThres;
  assign obsAdj      = sel ? bAdj      : aAdj;
  assign obsCount    = sel ? {14'd0, bCount} : aCount;

  function automatic exp_t model(input int n);
    exp_t e;
    int x, y, r, a;
    x = 3 + n % 10;
    y = 3 + n / 10;
    r = y * W + x;
    e.refAddr  = 8'(r);
    e.refPixel = 8'(r);
    for (int k = 0; k < 16; k++) begin
      a = r + DY[k] * W + DX[k];
      e.adj[k*8 +: 8] = 8'(a);
    end
    return e;
  endfunction

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(negedge clock);
    vecCount++;
    if ({aBusy, aDone, aMemRe, aPixValid} !== 4'b0000) begin
      missCount++;
      $display("[TB] FAIL reset_flags: got %b, need 0000", {aBusy, aDone, aMemRe, aPixValid});
    end
    vecCount++;
    if ({aMemAddr, aRefAddr, aRefPixel, aThres, aCount} !== '0 || aAdj !== '0) begin
      missCount++;
      $display("[TB] FAIL reset_data: memAddr=%0d refAddr=%0d refPixel=%0d thres=%0d count=%0d adj=%h, need all 0",
               aMemAddr, aRefAddr, aRefPixel, aThres, aCount, aAdj);
    end
    vecCount++;
    if ({bBusy, bCount, cBusy, cCount} !== '0) begin
      missCount++;
      $display("[TB] FAIL reset_others: bBusy=%b bCount=%0d cBusy=%b cCount=%0d, need 0", bBusy, bCount, cBusy, cCount);
    end
    nReset = 1'b1;
    @(negedge clock);
    vecCount++;
    if (aBusy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL idle_after_reset: busy=%b, need 0", aBusy);
    end
  endtask

  task automatic test_full_frame(input bit useB, input int lat, input int nCorner, input int expCount);
    exp_t e;
    int cyc, hs, lastHs, doneCyc;
    bit finished;
    logic [7:0] thr;
    cyc = 0; hs = 0; lastHs = -1; doneCyc = -1; finished = 1'b0;
    thr = useB ? 8'h3c : 8'h25;
    sel = useB; pixReady = 1'b1; cornerValid = 1'b0; isCorner = 1'b0;
    expQ.delete();
    for (int n = 0; n < 100; n++) expQ.push_back(model(n));
    @(negedge clock);
    thresIn = thr;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    vecCount++;
    if (obsBusy !== 1'b1 || obsCount !== 16'd0) begin
      missCount++;
      $display("[TB] FAIL start_accept: busy=%b count=%0d, need busy=1 count=0", obsBusy, obsCount);
    end
    while (!finished && cyc < 4000) begin
      cornerValid = 1'b0;
      isCorner    = 1'b0;
      if (obsPixValid === 1'b1) begin
        vecCount++;
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL extra_handshake: got handshake %0d, need at most 100", hs);
        end else begin
          e = expQ.pop_front();
          if ({obsMemRe, obsRefAddr, obsRefPixel, obsAdj} !== {1'b0, e.refAddr, e.refPixel, e.adj}) begin
            missCount++;
            $display("[TB] FAIL pix_data hs=%0d: got memRe=%b ref=%0d pix=%0d adj=%h, need memRe=0 ref=%0d pix=%0d adj=%h",
                     hs, obsMemRe, obsRefAddr, obsRefPixel, obsAdj, e.refAddr, e.refPixel, e.adj);
          end
        end
        vecCount++;
        if (hs == 0) begin
          if (cyc !== 17 + lat || obsAdj[7:0] !== 8'd3 || obsAdj[39:32] !== 8'd54) begin
            missCount++;
            $display("[TB] FAIL first_pixel: got cycle=%0d k0=%0d k4=%0d, need cycle=%0d k0=3 k4=54",
                     cyc, obsAdj[7:0], obsAdj[39:32], 17 + lat);
          end
        end else if (cyc - lastHs !== 19 + lat) begin
          missCount++;
          $display("[TB] FAIL pix_interval hs=%0d: got %0d cycles, need %0d", hs, cyc - lastHs, 19 + lat);
        end
        cornerValid = (hs < nCorner + 3);
        isCorner    = (hs < nCorner) || (hs >= nCorner + 3 && hs < nCorner + 6);
        lastHs = cyc;
        hs++;
      end
      if (obsDone === 1'b1) begin
        doneCyc  = cyc;
        finished = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    cornerValid = 1'b0;
    isCorner    = 1'b0;
    vecCount++;
    if (!finished || hs !== 100) begin
      missCount++;
      $display("[TB] FAIL frame_end: got done=%b handshakes=%0d, need done=1 handshakes=100", finished, hs);
    end
    vecCount++;
    if (doneCyc !== lastHs + 2) begin
      missCount++;
      $display("[TB] FAIL done_timing: got done at %0d, need %0d", doneCyc, lastHs + 2);
    end
    vecCount++;
    if (obsDone !== 1'b0 || obsBusy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL done_pulse: got done=%b busy=%b after pulse, need 0 0", obsDone, obsBusy);
    end
    vecCount++;
    if (obsCount !== 16'(expCount) || obsThres !== thr) begin
      missCount++;
      $display("[TB] FAIL corner_count: got count=%0d thres=%h, need count=%0d thres=%h",
               obsCount, obsThres, expCount, thr);
    end
  endtask

  task automatic test_start_ignored();
    sel = 1'b0; pixReady = 1'b0;
    @(negedge clock);
    thresIn = 8'h10;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    thresIn = 8'h99;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    vecCount++;
    if (aThres !== 8'h10 || aBusy !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL start_ignored: got thres=%h busy=%b, need thres=10 busy=1", aThres, aBusy);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int t;
    logic [AW-1:0] sRef;
    logic [7:0]    sPix;
    logic [127:0]  sAdj;
    t = 0;
    while (aPixValid !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    e = model(0);
    vecCount++;
    if (aPixValid !== 1'b1 || {aRefAddr, aRefPixel, aAdj} !== {e.refAddr, e.refPixel, e.adj}) begin
      missCount++;
      $display("[TB] FAIL stall_entry: got valid=%b ref=%0d adj=%h, need valid=1 ref=%0d adj=%h",
               aPixValid, aRefAddr, aAdj, e.refAddr, e.adj);
    end
    sRef = aRefAddr; sPix = aRefPixel; sAdj = aAdj;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      vecCount++;
      if ({aPixValid, aMemRe, aRefAddr, aRefPixel, aAdj} !== {1'b1, 1'b0, sRef, sPix, sAdj}) begin
        missCount++;
        $display("[TB] FAIL stall_hold cycle=%0d: got valid=%b memRe=%b ref=%0d pix=%0d, need valid=1 memRe=0 ref=%0d pix=%0d",
                 i, aPixValid, aMemRe, aRefAddr, aRefPixel, sRef, sPix);
      end
    end
    pixReady = 1'b1;
    @(negedge clock);
    vecCount++;
    if (aPixValid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL stall_release: got valid=%b after handshake, need 0", aPixValid);
    end
    @(negedge clock);
    vecCount++;
    if (aMemRe !== 1'b1 || aRefAddr !== 8'd52) begin
      missCount++;
      $display("[TB] FAIL stall_resume: got memRe=%b ref=%0d, need memRe=1 ref=52", aMemRe, aRefAddr);
    end
  endtask

  task automatic test_reset_midframe();
    bit sawDone;
    sawDone = 1'b0;
    repeat (3) @(negedge clock);
    vecCount++;
    if (aMemRe !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL abort_in_fetch: got memRe=%b, need 1", aMemRe);
    end
    nReset = 1'b0;
    #1;
    vecCount++;
    if ({aBusy, aDone, aMemRe, aPixValid, aMemAddr, aRefAddr, aRefPixel, aThres, aCount} !== '0 || aAdj !== '0) begin
      missCount++;
      $display("[TB] FAIL abort_outputs: busy=%b memRe=%b memAddr=%0d ref=%0d pix=%0d thres=%h count=%0d, need all 0",
               aBusy, aMemRe, aMemAddr, aRefAddr, aRefPixel, aThres, aCount);
    end
    @(negedge clock);
    nReset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (aDone !== 1'b0 || aBusy !== 1'b0) sawDone = 1'b1;
    end
    vecCount++;
    if (sawDone) begin
      missCount++;
      $display("[TB] FAIL abort_silent: got done/busy activity after abort, need none");
    end
  endtask

  task automatic test_degenerate();
    @(negedge clock);
    thresIn = 8'h42;
    cStart  = 1'b1;
    @(negedge clock);
    cStart = 1'b0;
    vecCount++;
    if ({cDone, cBusy, cMemRe} !== 3'b110 || cThres !== 8'h42) begin
      missCount++;
      $display("[TB] FAIL degen_done: got done=%b busy=%b memRe=%b thres=%h, need 1 1 0 42",
               cDone, cBusy, cMemRe, cThres);
    end
    @(negedge clock);
    vecCount++;
    if ({cDone, cBusy, cMemRe, cPixValid} !== 4'b0000 || cCount !== 16'd0) begin
      missCount++;
      $display("[TB] FAIL degen_idle: got done=%b busy=%b memRe=%b valid=%b count=%0d, need all 0",
               cDone, cBusy, cMemRe, cPixValid, cCount);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame(1'b0, 1, 7, 7);
    test_full_frame(1'b0, 1, 7, 7);
    test_start_ignored();
    test_stall();
    test_reset_midframe();
    test_full_frame(1'b1, 3, 5, 3);
    test_degenerate();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
